multi_channel_pattern_pwm: RTL

//  Parametrised multi-channel PWM/pattern generator, successor to the single 16-bit pattern-rotating pwm.

---
 rtl/multi_channel_pattern_pwm.sv | 90 +++++++++
 1 files changed

// File: rtl/multi_channel_pattern_pwm.sv
// Multi-channel PWM / serial-pattern generator with double-buffered per-channel settings.
// Each channel plays a WIDTH-clock period either as an MSB-first pattern or as a duty-cycle counter.
module multi_channel_pattern_pwm #(
  parameter int  WIDTH    = 16,
  parameter int  CHANNELS = 2,
  localparam int CW       = $clog2(WIDTH),
  localparam int SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SW-1:0]       ch_sel,
  input  logic                load,
  input  logic                wr,
  input  logic                mode_in,
  input  logic [WIDTH-1:0]    pattern_in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] period_done
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] r_act_pat;
    logic             r_act_mode;
    logic [WIDTH-1:0] r_shd_pat;
    logic             r_shd_mode;
    logic             r_shd_valid;
    logic [CW-1:0]    r_idx;
    logic             r_pd;

    logic             w_sel;
    logic             w_load;
    logic             w_wr;
    logic             w_wrap;
    logic [CW:0]      w_duty;
    logic             w_pat_bit;
    logic             w_duty_bit;

    // Out-of-range selects never match any channel, so such writes fall on the floor.
    assign w_sel  = (ch_sel == SW'(g));
    assign w_load = load && w_sel;
    assign w_wr   = wr && w_sel && !load;
    assign w_wrap = (r_idx == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_act_pat   <= '0;
        r_act_mode  <= 1'b0;
        r_shd_pat   <= '0;
        r_shd_mode  <= 1'b0;
        r_shd_valid <= 1'b0;
        r_idx       <= '0;
        r_pd        <= 1'b0;
      end else if (w_load) begin
        r_act_pat   <= pattern_in;
        r_act_mode  <= mode_in;
        r_shd_valid <= 1'b0;
        r_idx       <= '0;
        r_pd        <= 1'b0;
      end else begin
        r_pd <= 1'b0;
        if (en) begin
          r_idx <= r_idx + CW'(1);
          if (w_wrap) begin
            r_pd <= 1'b1;
            if (r_shd_valid) begin
              r_act_pat   <= r_shd_pat;
              r_act_mode  <= r_shd_mode;
              r_shd_valid <= 1'b0;
            end
          end
        end
        // A write landing on the wrap edge re-arms the shadow for the following wrap.
        if (w_wr) begin
          r_shd_pat   <= pattern_in;
          r_shd_mode  <= mode_in;
          r_shd_valid <= 1'b1;
        end
      end
    end

    // WIDTH is a power of two, so WIDTH-1-idx is simply the bitwise inverse of idx.
    assign w_pat_bit  = r_act_pat[~r_idx];
    assign w_duty     = r_act_pat[CW:0];
    assign w_duty_bit = ({1'b0, r_idx} < w_duty);

    assign out[g]         = r_act_mode ? w_duty_bit : w_pat_bit;
    assign period_done[g] = r_pd;
  end

endmodule
